// File: rtl/data_mem_responder.sv
// Fixed-latency word memory behind the cache data interface: one request in flight,
// completion reported by a one-cycle mem_ready pulse, byte lanes stored in per-lane banks.

module data_mem_lane #(
  parameter int IDX_W = 14,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [IDX_W-1:0] idx,
  input  logic [VEC_W-1:0] wdata,
  output logic [VEC_W-1:0] rdata
);
  logic [VEC_W-1:0] bank_q [2**IDX_W];
  logic [VEC_W-1:0] rdata_q, rdata_d;

  // Storage survives reset; only the read register is cleared.
  always_ff @(posedge clk)
    if (wr_en) bank_q[idx] <= wdata;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = rd_zero ? '0 : bank_q[idx];
  end

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) rdata_q <= '0;
    else        rdata_q <= rdata_d;

  assign rdata = rdata_q;
endmodule

module data_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            mem_req,
  input  logic [31:0]     mem_addr,
  input  logic            mem_write_en,
  input  logic [0:3][7:0] mem_data_in,
  output logic [0:3][7:0] mem_data_out,
  output logic            mem_ready,
  output logic            mem_busy,
  output logic            mem_err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int IDX_W     = ADDR_W - 2;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be 1..255");
  end
  if (ADDR_W < 3 || ADDR_W > 31) begin : g_bad_addr_w
    $error("data_mem_responder: ADDR_W must be 3..31");
  end

  typedef struct packed {
    logic [IDX_W-1:0]                  idx;
    logic                              we;
    logic                              err;
    logic [0:NUM_LANES-1][VEC_W-1:0]   data;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  req_t       req_q, req_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  req_t in_req, acc_req;
  logic access;
  logic unused_addr_lo;

  assign unused_addr_lo = ^mem_addr[1:0];

  always_comb begin
    in_req.idx  = mem_addr[ADDR_W-1:2];
    in_req.we   = mem_write_en;
    in_req.err  = |mem_addr[31:ADDR_W];
    in_req.data = mem_data_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    access  = 1'b0;
    acc_req = req_q;
    unique case (state_q)
      S_IDLE: if (mem_req) begin
        req_d  = in_req;
        cnt_d  = CNT_INIT;
        busy_d = 1'b1;
        if (LATENCY == 1) begin
          // Single-cycle memory: the accept edge is also the access edge.
          state_d = S_DONE;
          access  = 1'b1;
          acc_req = in_req;
          ready_d = 1'b1;
          err_d   = in_req.err;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
          access  = 1'b1;
          ready_d = 1'b1;
          err_d   = req_q.err;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end

  // Writes are gated by reset so an aborted request can never reach the banks.
  logic lane_wr, lane_rd;
  assign lane_wr = access && rst_b && acc_req.we && !acc_req.err;
  assign lane_rd = access && !acc_req.we;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    data_mem_lane #(.IDX_W(IDX_W), .VEC_W(VEC_W)) u_lane (
      .clk     (clk),
      .rst_b   (rst_b),
      .wr_en   (lane_wr),
      .rd_en   (lane_rd),
      .rd_zero (acc_req.err),
      .idx     (acc_req.idx),
      .wdata   (acc_req.data[l]),
      .rdata   (mem_data_out[l])
    );
  end

  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;
  assign mem_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a timestamp-based transaction model checked
// every cycle, plus literal expectations for latency, lane order, errors and reset abort.

module tb_data_mem_responder;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            mem_req = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic            mem_write_en = 1'b0;
  logic [0:3][7:0] mem_data_in = '0;
  logic [0:3][7:0] mem_data_out;
  logic            mem_ready, mem_busy, mem_err;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.ADDR_W(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_busy(mem_busy),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a request accepted at edge k completes on edge k+LAT-1 and frees at k+LAT.
  logic [31:0] mem_m [0:16383];
  int          edge_n = 0, m_done = 0, m_free = 0;
  bit          m_busy = 0, m_we = 0, m_err = 0;
  logic [13:0] m_idx = '0;
  logic [31:0] m_data = '0;
  logic [31:0] exp_data = '0;
  bit          exp_ready = 0, exp_err = 0;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      m_busy    <= 0;
      exp_ready <= 0;
      exp_err   <= 0;
      exp_data  <= '0;
    end else begin
      edge_n    <= edge_n + 1;
      exp_ready <= 0;
      exp_err   <= 0;
      if (m_busy && edge_n == m_free) m_busy <= 0;
      else if (!m_busy && mem_req) begin
        m_busy <= 1;
        m_idx  <= mem_addr[15:2];
        m_we   <= mem_write_en;
        m_err  <= |mem_addr[31:16];
        m_data <= mem_data_in;
        m_done <= edge_n + LAT - 1;
        m_free <= edge_n + LAT;
      end
      if (m_busy && edge_n == m_done) begin
        exp_ready <= 1;
        exp_err   <= m_err;
        if (m_err) begin
          if (!m_we) exp_data <= '0;
        end else if (m_we) mem_m[m_idx] <= m_data;
        else exp_data <= mem_m[m_idx];
      end
    end

  always @(negedge clk) begin
    chk("ready", 32'(mem_ready), 32'(exp_ready));
    chk("err",   32'(mem_err),   32'(exp_err));
    chk("busy",  32'(mem_busy),  32'(m_busy));
    chk("data",  mem_data_out,   exp_data);
  end

  task automatic xact(input logic [31:0] a, input logic we, input logic [31:0] d,
                      input bit scramble, output int lat, output bit err_seen);
    @(negedge clk);
    mem_addr = a; mem_write_en = we; mem_data_in = d; mem_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 1) begin
        mem_addr = ~a; mem_write_en = ~we; mem_data_in = ~d;
      end
    end while (!mem_ready && lat < 20);
    if (lat >= 20) chk("timeout", 32'(lat), 32'(LAT));
    err_seen = mem_err;
    mem_req = 1'b0;
  endtask

  initial begin
    int lat, n, lowc;
    bit e;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_busy",  32'(mem_busy),  32'h0);
    chk("rst_data",  mem_data_out,   32'h0);
    rst_b = 1'b1;

    // 1: write then read back, latency LAT
    xact(32'h0010, 1, 32'h1122_3344, 0, lat, e);
    chk("t1_wlat", 32'(lat), 32'd4);
    chk("t1_werr", 32'(e), 32'h0);
    xact(32'h0010, 0, 32'h0, 0, lat, e);
    chk("t1_rlat", 32'(lat), 32'd4);
    chk("t1_rdata", mem_data_out, 32'h1122_3344);

    // 2: lane order, low address bits ignored
    xact(32'h0004, 1, 32'hA1B2_C3D4, 0, lat, e);
    xact(32'h0006, 0, 32'h0, 0, lat, e);
    chk("t2_lane0", 32'(mem_data_out[0]), 32'hA1);
    chk("t2_lane3", 32'(mem_data_out[3]), 32'hD4);

    // 3: back-to-back requests with mem_req held high
    xact(32'h0000, 1, 32'h0102_0304, 0, lat, e);
    @(negedge clk);
    mem_addr = 32'h0; mem_write_en = 1'b0; mem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0; lowc = 0;
      do begin
        @(negedge clk);
        n++;
        if (!mem_busy) lowc++;
      end while (!mem_ready && n < 20);
      if (k > 0) begin
        chk("t3_gap", 32'(n), 32'd5);
        chk("t3_busy_low", 32'(lowc), 32'd1);
      end
      chk("t3_data", mem_data_out, (k % 2 == 0) ? 32'h0102_0304 : 32'hA1B2_C3D4);
      mem_addr = (k % 2 == 0) ? 32'h4 : 32'h0;
    end
    mem_req = 1'b0;

    // 4: inputs change while busy; only accepted values matter
    xact(32'h0030, 1, 32'h7777_1234, 1, lat, e);
    chk("t4_lat", 32'(lat), 32'd4);
    xact(32'h0030, 0, 32'h0, 0, lat, e);
    chk("t4_rdata", mem_data_out, 32'h7777_1234);

    // 5: reset aborts an in-flight write
    xact(32'h0020, 1, 32'h5555_AAAA, 0, lat, e);
    xact(32'h0010, 0, 32'h0, 0, lat, e);
    @(negedge clk);
    mem_addr = 32'h0020; mem_write_en = 1'b1; mem_data_in = 32'hCAFE_F00D; mem_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy",  32'(mem_busy),  32'h0);
    chk("t5_rst_ready", 32'(mem_ready), 32'h0);
    chk("t5_rst_data",  mem_data_out,   32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    xact(32'h0020, 0, 32'h0, 0, lat, e);
    chk("t5_old", mem_data_out, 32'h5555_AAAA);

    // 6: out-of-range read and write
    xact(32'h0001_0000, 0, 32'h0, 0, lat, e);
    chk("t6_rlat", 32'(lat), 32'd4);
    chk("t6_rerr", 32'(e), 32'h1);
    chk("t6_rdata", mem_data_out, 32'h0);
    xact(32'h0001_0000, 1, 32'hDEAD_BEEF, 0, lat, e);
    chk("t6_werr", 32'(e), 32'h1);
    xact(32'h0000, 0, 32'h0, 0, lat, e);
    chk("t6_alias", mem_data_out, 32'h0102_0304);
    chk("t6_okerr", 32'(e), 32'h0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
